fxp32_add_arb: RTL and testbench

Round-robin arbiter and two-stage sequencer that shares one `fxp32_cla` 32-bit fixed-point adder between `NREQ` requesters. It accepts one add/subtract request per cycle and registers the operands into the adder. It returns the registered sum, signed-overflow flag and requester id through a valid/ready result port. It sits between the fixed-point compute lanes and the single shared adder instance.

---
 rtl/fxp32_pkg.sv | 12 +
 rtl/fxp32_cla.sv | 40 ++++
 rtl/fxp32_rr_arb.sv | 37 +++
 rtl/fxp32_add_arb.sv | 113 +++++++++++
 tb/tb_fxp32_add_arb.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fxp32_pkg.sv
// Shared fixed-point types and constants for the fxp32 adder slice.
// Q-format agnostic: values are plain 32-bit two's complement words.
package fxp32_pkg;

  localparam int FXP32_WIDTH = 32;

  typedef logic signed [FXP32_WIDTH-1:0] fxp32_t;

  localparam fxp32_t FXP32_MAX = 32'sh7FFF_FFFF;
  localparam fxp32_t FXP32_MIN = 32'sh8000_0000;

endpackage

// File: rtl/fxp32_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with rippled group
// carries. ovf is carry into bit 31 XOR carry out of bit 31.
module fxp32_cla
  import fxp32_pkg::*;
(
  input  fxp32_t a,
  input  fxp32_t b,
  input  logic   cin,
  output fxp32_t sum,
  output logic   ovf
);

  logic [FXP32_WIDTH-1:0] g, p;
  logic [FXP32_WIDTH:0]   c;
  logic [FXP32_WIDTH/4:0] gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c     = '0;
    gc    = '0;
    gc[0] = cin;
    for (int k = 0; k < FXP32_WIDTH/4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      gc[k+1]  = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    c[FXP32_WIDTH] = gc[FXP32_WIDTH/4];
  end

  assign sum = p ^ c[FXP32_WIDTH-1:0];
  assign ovf = c[FXP32_WIDTH-1] ^ c[FXP32_WIDTH];

endmodule

// File: rtl/fxp32_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or
// above ptr (wrapping), only while en is high. ptr is held by the parent.
module fxp32_rr_arb #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW:0]   pos;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    pos    = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // pos is one bit wider than ptr so the wrap works for any NREQ
      pos = {1'b0, ptr} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NREQ)) pos = pos - (IDW+1)'(NREQ);
      idx = pos[IDW-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/fxp32_add_arb.sv
// Round-robin front end sharing one fxp32_cla between NREQ requesters via a
// two-stage (operand, result) pipeline. Saturation: FXP32_ADD_ARB_SAT_EN.
module fxp32_add_arb
  import fxp32_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]    req_sub,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_sum,
  output logic               res_ovf,
  output logic [IDW-1:0]     res_id
);

  // Handshakes: a transfer happens on a port in any cycle where both its
  // valid and ready are high at the rising edge; valid never waits on ready.
  logic           op_vld, op_cin;
  fxp32_t         op_a, op_b;
  logic [IDW-1:0] op_id, ptr;
  logic           adv1, adv2, hs;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  fxp32_t         sel_a, sel_b, cla_sum, sum_sel;
  logic           sel_sub, cla_ovf;

  assign adv2 = op_vld & (~res_valid | res_ready);
  assign adv1 = ~op_vld | adv2;

  // rst gates the grant so req_ready reads 0 while reset is held
  fxp32_rr_arb #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .en     (adv1 & ~rst),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign hs        = |gnt;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_sub = req_sub[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_vld <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
      op_id  <= '0;
      ptr    <= '0;
    end else if (hs) begin
      op_vld <= 1'b1;
      op_a   <= sel_a;
      op_b   <= sel_sub ? ~sel_b : sel_b;
      op_cin <= sel_sub;
      op_id  <= gnt_id;
      ptr    <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
    end else if (adv2) begin
      op_vld <= 1'b0;
    end
  end

  fxp32_cla u_cla (
    .a   (op_a),
    .b   (op_b),
    .cin (op_cin),
    .sum (cla_sum),
    .ovf (cla_ovf)
  );

`ifdef FXP32_ADD_ARB_SAT_EN
  // Overflow needs A and B' of equal sign, so A's sign picks the rail
  assign sum_sel = cla_ovf ? (op_a[31] ? FXP32_MIN : FXP32_MAX) : cla_sum;
`else
  assign sum_sel = cla_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_ovf   <= 1'b0;
      res_id    <= '0;
    end else if (adv2) begin
      res_valid <= 1'b1;
      res_sum   <= sum_sel;
      res_ovf   <= cla_ovf;
      res_id    <= op_id;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fxp32_add_arb.sv
// Directed self-checking bench for fxp32_add_arb (NREQ=4).
// Inputs change on the falling edge; outputs are checked there too.
module tb_fxp32_add_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a = '0;
  logic [NREQ*32-1:0] req_b = '0;
  logic [NREQ-1:0]    req_sub = '0;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic [31:0]        res_sum;
  logic               res_ovf;
  logic [IDW-1:0]     res_id;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0]    exp_q[$];
  logic [IDW-1:0] exp_id_q[$];

  fxp32_add_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_ovf   (res_ovf),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic sub);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_sub[i]        = sub;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_cmp++; if (res_sum !== 32'h0) begin n_fail++; $display("FAIL reset_res_sum: got %h want 0", res_sum); end
    n_cmp++; if (res_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_res_ovf: got %b want 0", res_ovf); end
    n_cmp++; if (res_id !== 2'd0) begin n_fail++; $display("FAIL reset_res_id: got %0d want 0", res_id); end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single(input string name, input int idx, input logic [31:0] a,
                             input logic [31:0] b, input logic sub,
                             input logic [31:0] exp_sum, input logic exp_ovf);
    logic [NREQ-1:0] exp_gnt;
    exp_gnt = NREQ'(1 << idx);
    @(negedge clk);
    res_ready = 1'b1;
    set_op(idx, a, b, sub);
    req_valid = exp_gnt;
    #1;
    n_cmp++; if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL %s_grant: got %b want %b", name, req_ready, exp_gnt); end
    @(negedge clk);
    req_valid = '0;
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early_valid: got %b want 0", name, res_valid); end
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b want 1", name, res_valid); end
    n_cmp++; if (res_sum !== exp_sum) begin n_fail++; $display("FAIL %s_sum: got %h want %h", name, res_sum, exp_sum); end
    n_cmp++; if (res_ovf !== exp_ovf) begin n_fail++; $display("FAIL %s_ovf: got %b want %b", name, res_ovf, exp_ovf); end
    n_cmp++; if (res_id !== IDW'(idx)) begin n_fail++; $display("FAIL %s_id: got %0d want %0d", name, res_id, idx); end
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL %s_drain: got %b want 0", name, res_valid); end
  endtask

  task automatic test_round_robin();
    logic [31:0] a_v[NREQ];
    logic [31:0] b_v[NREQ];
    int g;
    logic [31:0] got_exp;
    logic [IDW-1:0] got_id;
    pulse_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = 32'h0000_1000 * (i + 1);
      b_v[i] = 32'(i + 5);
      set_op(i, a_v[i], b_v[i], 1'b0);
    end
    res_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 2) begin
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rr_fill_valid c%0d: got %b want 0", c, res_valid); end
      end else begin
        got_exp = exp_q.pop_front();
        got_id  = exp_id_q.pop_front();
        n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid c%0d: got %b want 1", c, res_valid); end
        n_cmp++; if (res_id !== got_id) begin n_fail++; $display("FAIL rr_id c%0d: got %0d want %0d", c, res_id, got_id); end
        n_cmp++; if (res_sum !== got_exp) begin n_fail++; $display("FAIL rr_sum c%0d: got %h want %h", c, res_sum, got_exp); end
      end
      if (c < 5) begin
        req_valid = 4'b1111;
        g = c % NREQ;
        #1;
        n_cmp++; if (req_ready !== NREQ'(1 << g)) begin n_fail++; $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, NREQ'(1 << g)); end
        exp_q.push_back(a_v[g] + b_v[g]);
        exp_id_q.push_back(IDW'(g));
      end else begin
        req_valid = '0;
      end
    end
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rr_empty: got %b want 0", res_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] e_sum;
    logic [IDW-1:0] e_id;
    pulse_reset();
    set_op(0, 32'h0000_0100, 32'h0000_0001, 1'b0);
    set_op(1, 32'h0000_0200, 32'h0000_0002, 1'b1);
    set_op(2, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
    @(negedge clk);
    res_ready = 1'b0;
    req_valid = 4'b0111;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_grant0: got %b want 0001", req_ready); end
    exp_q.push_back(32'h0000_0101); exp_id_q.push_back(2'd0);
    @(negedge clk);
    req_valid = 4'b0110;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant1: got %b want 0010", req_ready); end
    exp_q.push_back(32'h0000_01FE); exp_id_q.push_back(2'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req_valid = 4'b0100;
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_full c%0d: got %b want 0000", c, req_ready); end
      n_cmp++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin n_fail++; $display("FAIL bp_hold c%0d: got v=%b id=%0d want v=1 id=0", c, res_valid, res_id); end
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_drain_grant: got %b want 0100", req_ready); end
    exp_q.push_back(32'h0000_0002); exp_id_q.push_back(2'd2);
    for (int c = 0; c < 3; c++) begin
      e_sum = exp_q.pop_front();
      e_id  = exp_id_q.pop_front();
      n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid c%0d: got %b want 1", c, res_valid); end
      n_cmp++; if (res_id !== e_id) begin n_fail++; $display("FAIL bp_out_id c%0d: got %0d want %0d", c, res_id, e_id); end
      n_cmp++; if (res_sum !== e_sum) begin n_fail++; $display("FAIL bp_out_sum c%0d: got %h want %h", c, res_sum, e_sum); end
      @(negedge clk);
      req_valid = '0;
    end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", res_valid); end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    set_op(2, 32'h1234_0000, 32'h0000_5678, 1'b0);
    set_op(1, 32'h0000_0010, 32'h0000_0020, 1'b0);
    set_op(3, 32'h0000_0030, 32'h0000_0040, 1'b0);
    res_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL mid_grant2: got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_result c%0d: got %b want 0", c, res_valid); end
      @(negedge clk);
    end
    req_valid = 4'b1010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_sum !== 32'h0000_0030) begin
      n_fail++; $display("FAIL mid_result: got v=%b id=%0d sum=%h want v=1 id=1 sum=00000030", res_valid, res_id, res_sum);
    end
    @(negedge clk);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single("add", 0, 32'h0001_0000, 32'h0002_8000, 1'b0, 32'h0003_8000, 1'b0);
`ifdef FXP32_ADD_ARB_SAT_EN
    test_single("sub_ovf", 2, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1);
    test_single("pos_ovf", 3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1);
`else
    test_single("sub_ovf", 2, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1);
    test_single("pos_ovf", 3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1);
`endif
    test_single("sub_neg", 1, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0);
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
